// File: rtl/spi_minion.sv
// -----------------------------------------------------------------------------
// spi_minion
// SPI peripheral end of the SPI link: mode 0 (CPOL=0, CPHA=0), MSB first.
// The asynchronous pins cs/sclk/mosi are oversampled with clk. Received words
// are presented on a val/rdy send interface; a word accepted on the val/rdy
// recv interface is shifted out on miso during the next transfer.
//
// Ports
//   clk       in   1      system clock
//   reset     in   1      synchronous, active-high reset
//   cs        in   1      chip select from master, active low, async to clk
//   sclk      in   1      serial clock from master, async to clk
//   mosi      in   1      serial data from master
//   miso      out  1      serial data to master (always driven)
//   recv_msg  in   nbits  word to transmit on the next transfer
//   recv_val  in   1      recv_msg valid
//   recv_rdy  out  1      tx buffer empty
//   send_msg  out  nbits  last word received from the master
//   send_val  out  1      send_msg valid, held until accepted
//   send_rdy  in   1      downstream accepts send_msg
//   overflow  out  1      one-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module spi_minion #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    input  logic [nbits-1:0] recv_msg,
    input  logic             recv_val,
    output logic             recv_rdy,
    output logic [nbits-1:0] send_msg,
    output logic             send_val,
    input  logic             send_rdy,
    output logic             overflow
);

    localparam int CW = $clog2(nbits + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Synchroniser chains: index 0 is the first stage. Stage 1 is the
    // synchronised value, stage 2 (cs/sclk only) is its delayed copy for
    // edge detection.
    logic [2:0] r_cs_sync;
    logic [2:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;

    logic [nbits-1:0] r_tx_buf;
    logic             r_tx_buf_valid;
    logic [nbits-1:0] r_tx_shift;
    // Only nbits-1 history bits are kept; the newest bit comes straight from
    // the synchroniser when the word completes.
    logic [nbits-2:0] r_rx_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [nbits-1:0] r_send_msg;
    logic             r_send_val;
    logic             r_overflow;

    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_mosi_s;
    logic             w_recv_fire;
    logic             w_last_bit;
    logic             w_accept;
    logic             w_send_fire;
    logic [nbits-1:0] w_rx_word;

    // -------------------------------------------------------------------------
    // Input synchronisers. cs resets high so an idle bus does not look like
    // a falling edge straight out of reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= 3'b111;
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], cs};
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_cs_fall   =  r_cs_sync[2]   & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_sync[2]   &  r_cs_sync[1];
    assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];
    assign w_mosi_s    =  r_mosi_sync[1];

    assign recv_rdy    = ~r_tx_buf_valid;
    assign w_recv_fire = recv_val & ~r_tx_buf_valid;
    assign w_send_fire = r_send_val & send_rdy;
    assign w_accept    = ~r_send_val | send_rdy;
    assign w_rx_word   = {r_rx_shift, w_mosi_s};
    assign w_last_bit  = w_sclk_rise && (r_bit_cnt == CW'(nbits - 1));

    assign send_msg = r_send_msg;
    assign send_val = r_send_val;
    assign overflow = r_overflow;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and miso. A cs rise in SHIFT takes priority over a
    // coincident sclk edge so an abort never completes a word.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        miso         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                miso = r_tx_shift[nbits-1];
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end else if (w_last_bit) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: tx buffer, shift registers, bit counter, send interface.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_buf       <= '0;
            r_tx_buf_valid <= 1'b0;
            r_tx_shift     <= '0;
            r_rx_shift     <= '0;
            r_bit_cnt      <= '0;
            r_send_msg     <= '0;
            r_send_val     <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_overflow <= 1'b0;

            if (w_send_fire) begin
                r_send_val <= 1'b0;
            end

            if (r_state == IDLE && w_cs_fall) begin
                r_bit_cnt <= '0;
                if (w_recv_fire) begin
                    // Word arriving in the start cycle goes straight to the
                    // shifter; the buffer stays empty.
                    r_tx_shift <= recv_msg;
                end else begin
                    r_tx_shift     <= r_tx_buf_valid ? r_tx_buf : '0;
                    r_tx_buf_valid <= 1'b0;
                end
            end else if (w_recv_fire) begin
                r_tx_buf       <= recv_msg;
                r_tx_buf_valid <= 1'b1;
            end

            if (r_state == SHIFT && !w_cs_rise) begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_word[nbits-2:0];
                    r_bit_cnt  <= r_bit_cnt + CW'(1);
                    if (w_last_bit) begin
                        if (w_accept) begin
                            r_send_msg <= w_rx_word;
                            r_send_val <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                // The MSB is already on miso for the first rising edge, so
                // shifting starts with the fall after bit 0 was sampled.
                if (w_sclk_fall && r_bit_cnt != '0) begin
                    r_tx_shift <= {r_tx_shift[nbits-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_minion.sv
// -----------------------------------------------------------------------------
// tb_spi_minion
// Drives the SPI pins as a mode-0 master and checks the spi_minion send
// interface against a queue of expected words, plus miso data, overflow,
// abort, bypass and reset behaviour.
// -----------------------------------------------------------------------------
module tb_spi_minion;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic [NB-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [NB-1:0] send_msg;
    logic          send_val;
    logic          send_rdy;
    logic          overflow;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            ovf_cnt = 0;
    logic [NB-1:0] exp_q[$];

    spi_minion #(.nbits(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted send handshake must match the oldest
    // expected word.
    always @(negedge clk) begin
        logic [NB-1:0] e;
        if (!reset && overflow) begin
            ovf_cnt++;
        end
        if (!reset && send_val && send_rdy) begin
            check_val("rx_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("rx_word", 32'(send_msg), 32'(e));
                $display("[TB] rx word %h (expected %h)", send_msg, e);
            end
        end
    end

    // Advance n clocks and settle just after the edge before driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [NB-1:0] m);
        recv_msg = m;
        recv_val = 1'b1;
        tick(1);
        recv_val = 1'b0;
    endtask

    task automatic cs_low(input bit byp, input logic [NB-1:0] bm);
        cs = 1'b0;
        if (byp) begin
            // The synchronised cs fall acts on the third edge after the pin
            // change; offer the recv word exactly on that edge.
            tick(2);
            recv_msg = bm;
            recv_val = 1'b1;
            tick(1);
            recv_val = 1'b0;
            check_val("byp_rdy", 32'(recv_rdy), 32'd1);
            tick(3);
        end else begin
            tick(6);
        end
    endtask

    task automatic send_bit(input logic b, output logic mb);
        mosi = b;
        tick(6);
        mb   = miso;
        sclk = 1'b1;
        tick(6);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic [NB-1:0] w, input int nb, input bit byp,
                        input logic [NB-1:0] bm, output logic [NB-1:0] mw);
        logic mb;
        mw = '0;
        cs_low(byp, bm);
        for (int i = 0; i < nb; i++) begin
            send_bit(w[NB-1-i], mb);
            mw[NB-1-i] = mb;
        end
        tick(6);
        if (nb == NB) begin
            check_val("hold_miso", 32'(miso), 32'd0);
        end
        cs = 1'b1;
        tick(8);
        $display("[TB] xfer mosi=%h bits=%0d miso=%h", w, nb, mw);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] mw;
        logic          mb;
        int            ovf0;

        reset    = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        recv_msg = '0;
        recv_val = 1'b0;
        send_rdy = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);
        check_val("rst_miso",     32'(miso),     32'd0);
        check_val("rst_send_val", 32'(send_val), 32'd0);
        check_val("rst_send_msg", 32'(send_msg), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_recv_rdy", 32'(recv_rdy), 32'd1);

        // 1: loaded tx word A5, master sends 3C
        push_tx(8'hA5);
        check_val("t1_rdy_full", 32'(recv_rdy), 32'd0);
        exp_q.push_back(8'h3C);
        xfer(8'h3C, NB, 1'b0, 8'h00, mw);
        check_val("t1_miso", 32'(mw), 32'hA5);
        check_val("t1_rdy_back", 32'(recv_rdy), 32'd1);
        check_val("t1_send_msg", 32'(send_msg), 32'h3C);

        // 2: nothing loaded, master sends FF
        exp_q.push_back(8'hFF);
        xfer(8'hFF, NB, 1'b0, 8'h00, mw);
        check_val("t2_miso", 32'(mw), 32'h00);

        // 3: downstream stalled, second word overflows
        send_rdy = 1'b0;
        ovf0 = ovf_cnt;
        exp_q.push_back(8'h11);
        xfer(8'h11, NB, 1'b0, 8'h00, mw);
        xfer(8'h22, NB, 1'b0, 8'h00, mw);
        check_val("t3_send_msg", 32'(send_msg), 32'h11);
        check_val("t3_send_val", 32'(send_val), 32'd1);
        check_val("t3_ovf_cnt", 32'(ovf_cnt - ovf0), 32'd1);
        send_rdy = 1'b1;
        tick(3);
        check_val("t3_val_clr", 32'(send_val), 32'd0);

        // 4: abort after 5 bits, then a full transfer
        ovf0 = ovf_cnt;
        xfer(8'hF0, 5, 1'b0, 8'h00, mw);
        check_val("t4_no_val", 32'(send_val), 32'd0);
        check_val("t4_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
        exp_q.push_back(8'h0F);
        xfer(8'h0F, NB, 1'b0, 8'h00, mw);
        check_val("t4_send_msg", 32'(send_msg), 32'h0F);

        // 5: recv handshake in the cs-fall cycle bypasses the buffer
        exp_q.push_back(8'h96);
        xfer(8'h96, NB, 1'b1, 8'h81, mw);
        check_val("t5_miso", 32'(mw), 32'h81);
        check_val("t5_rdy", 32'(recv_rdy), 32'd1);

        // 6: reset mid-transfer
        cs_low(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, mb);
        end
        push_tx(8'h77);
        check_val("t6_rdy_full", 32'(recv_rdy), 32'd0);
        reset = 1'b1;
        tick(1);
        check_val("t6_miso",     32'(miso),     32'd0);
        check_val("t6_send_val", 32'(send_val), 32'd0);
        check_val("t6_send_msg", 32'(send_msg), 32'd0);
        check_val("t6_overflow", 32'(overflow), 32'd0);
        check_val("t6_recv_rdy", 32'(recv_rdy), 32'd1);
        tick(1);
        reset = 1'b0;
        tick(6);
        cs = 1'b1;
        tick(8);
        exp_q.push_back(8'h5A);
        xfer(8'h5A, NB, 1'b0, 8'h00, mw);
        check_val("t6_miso_word", 32'(mw), 32'h00);
        check_val("t6_send_msg2", 32'(send_msg), 32'h5A);

        tick(4);
        check_val("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
